mod_inverse: RTL and testbench

- Sequential modular inverter over Z_q, q = 3329 (Kyber field). It is the divide-side counterpart of mod_multiplier.
- Computes y = a^(q-2) mod q (Fermat) by left-to-right square-and-multiply, time-sharing one mod_multiplier instance.
- Used for inverse-NTT scaling constants (n^-1) and for runtime twiddle and coefficient inversion.
- Valid/ready handshake on both sides; one operation in flight at a time.

---
 rtl/ntt_pkg.sv | 16 +
 rtl/mod_inverse_if.sv | 36 +++
 rtl/mod_multiplier.sv | 21 ++
 rtl/mod_inverse.sv | 129 ++++++++++++
 tb/tb_mod_inverse.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT definitions: field modulus, coefficient width and inverter FSM states.
package ntt_pkg;

    localparam int unsigned Q = 3329;
    localparam int unsigned W = 12;

    typedef logic [W-1:0] coeff_t;

    typedef enum logic [1:0] {
        IDLE,
        SQR,
        MUL,
        DONE
    } inv_state_t;

endpackage

// File: rtl/mod_inverse_if.sv
// Operand/result valid-ready bundle for mod_inverse.
interface mod_inverse_if #(
    parameter int unsigned W = ntt_pkg::W
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         err;

    // Requester side: supplies operands and consumes results.
    modport master (
        output in_valid,
        output a,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  y,
        input  err
    );

    // Inverter side.
    modport slave (
        input  in_valid,
        input  a,
        input  out_ready,
        output in_ready,
        output out_valid,
        output y,
        output err
    );

endinterface

// File: rtl/mod_multiplier.sv
// Combinational modular multiplier: y = (a * b) mod Q, result always < Q.
module mod_multiplier #(
    parameter int unsigned Q = ntt_pkg::Q,
    parameter int unsigned W = ntt_pkg::W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    localparam logic [2*W-1:0] MODQ = (2*W)'(Q);

    logic [2*W-1:0] prod;

    // Full-width product followed by reduction; operands need not be reduced.
    always_comb begin
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        y    = W'(prod % MODQ);
    end

endmodule

// File: rtl/mod_inverse.sv
// Sequential Fermat inverter over Z_Q: y = a^(Q-2) mod Q via left-to-right
// square-and-multiply, time-sharing one combinational mod_multiplier.
module mod_inverse
    import ntt_pkg::*;
#(
    parameter int unsigned Q = ntt_pkg::Q,
    parameter int unsigned W = ntt_pkg::W
) (
    input  logic        clk,
    input  logic        rst,
    mod_inverse_if.slave bus
);

    localparam int unsigned  IW        = $clog2(W);
    localparam logic [W-1:0] EXP       = W'(Q - 2);
    localparam logic [W-1:0] Q_C       = W'(Q);
    // Loading acc with a consumes the exponent MSB (bit W-1), so scanning starts one below.
    localparam logic [IW-1:0] IDX_START = IW'(W - 2);

    inv_state_t    state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  a_reg_q, a_reg_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          err_reg_q, err_reg_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  y_q, y_d;
    logic          err_q, err_d;

    logic [W-1:0]  mul_b;
    logic [W-1:0]  mul_y;
    logic          accept;

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.err       = err_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign mul_b  = (state_q == MUL) ? a_reg_q : acc_q;

    mod_multiplier #(
        .Q(Q),
        .W(W)
    ) u_mul (
        .a(acc_q),
        .b(mul_b),
        .y(mul_y)
    );

    // State register and datapath flops; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            a_reg_q     <= '0;
            idx_q       <= '0;
            err_reg_q   <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            a_reg_q     <= a_reg_d;
            idx_q       <= idx_d;
            err_reg_q   <= err_reg_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            err_q       <= err_d;
        end
    end

    // Next-state and datapath: square every bit, multiply on set exponent bits.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        a_reg_d     = a_reg_q;
        idx_d       = idx_q;
        err_reg_d   = err_reg_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        err_d       = err_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_reg_d   = bus.a;
                    acc_d     = bus.a;
                    idx_d     = IDX_START;
                    err_reg_d = (bus.a == '0) || (bus.a >= Q_C);
                    state_d   = SQR;
                end
            end
            SQR: begin
                acc_d = mul_y;
                if (EXP[idx_q]) begin
                    state_d = MUL;
                end else if (idx_q == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    y_d         = err_reg_q ? '0 : mul_y;
                    err_d       = err_reg_q;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            MUL: begin
                acc_d = mul_y;
                if (idx_q == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    y_d         = err_reg_q ? '0 : mul_y;
                    err_d       = err_reg_q;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    state_d = SQR;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mod_inverse.sv
// Scoreboard bench for mod_inverse: stimulus pushes expected results, a
// negedge monitor compares value, error flag and latency of each result.
module tb_mod_inverse;
    import ntt_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mod_inverse_if #(.W(W)) bus ();

    mod_inverse #(
        .Q(Q),
        .W(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int   a;
        int   y;
        logic err;
        int   acc_edge;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   edges    = 0;

    localparam int LATENCY = 20;

    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference inverse by extended Euclid.
    function automatic int inv_ref(input int x);
        int t = 0, nt = 1, r = 3329, nr = x, qq, tmp;
        while (nr != 0) begin
            qq  = r / nr;
            tmp = t - qq * nt; t = nt; nt = tmp;
            tmp = r - qq * nr; r = nr; nr = tmp;
        end
        if (t < 0) t += 3329;
        return t;
    endfunction

    // Monitor: every cycle a result is presented it must match the queue head.
    initial begin
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_out_valid: got y=%0d err=%0d, expected no result", bus.y, bus.err);
                end else begin
                    if (!prev_v)
                        check($sformatf("latency(a=%0d)", sb[0].a), edges - sb[0].acc_edge, LATENCY);
                    check($sformatf("y(a=%0d)", sb[0].a), int'(bus.y), sb[0].y);
                    check($sformatf("err(a=%0d)", sb[0].a), int'(bus.err), int'(sb[0].err));
                    check("in_ready_while_done", int'(bus.in_ready), 0);
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end
            if (!rst) prev_v = bus.out_valid;
        end
    end

    // Present an operand and hold in_valid until accepted; record expectation.
    task automatic issue(input int av, input int ey, input logic ee);
        int n;
        bit ok;
        logic [31:0] av_v;
        n    = 0;
        ok   = 1'b0;
        av_v = av;
        bus.a        = av_v[W-1:0];
        bus.in_valid = 1'b1;
        while (n < 200 && !ok) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back('{av, ey, ee, edges + 1});
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
            n++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: a=%0d got no in_ready, expected accept", av);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    int vec_a[6] = '{1, 2, 17, 3328, 0, 3500};
    int vec_y[6] = '{1, 1665, 1175, 3328, 0, 0};
    bit vec_e[6] = '{0, 0, 0, 0, 1, 1};

    initial begin
        int n;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.out_ready = 1'b1;

        #12;
        check("reset_in_ready", int'(bus.in_ready), 0);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_y", int'(bus.y), 0);
        check("reset_err", int'(bus.err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("release_in_ready", int'(bus.in_ready), 1);

        // Basic and error operands, one at a time.
        for (int i = 0; i < 6; i++) begin
            issue(vec_a[i], vec_y[i], vec_e[i]);
            bus.in_valid = 1'b0;
            drain();
        end

        // Backpressure with an ignored concurrent request.
        bus.out_ready = 1'b0;
        issue(2, 1665, 1'b0);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_seen", int'(bus.out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.a        = 12'd5;
            @(negedge clk);
            check("bp_in_ready", int'(bus.in_ready), 0);
            check("bp_out_valid_held", int'(bus.out_valid), 1);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_after_in_ready", int'(bus.in_ready), 1);
        check("bp_after_out_valid", int'(bus.out_valid), 0);
        check("bp_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;

        // Reset in the middle of an operation.
        issue(17, 1175, 1'b0);
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_y", int'(bus.y), 0);
        check("midrst_in_ready", int'(bus.in_ready), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        issue(2, 1665, 1'b0);
        bus.in_valid = 1'b0;
        drain();

        // Back-to-back stream with in_valid held high.
        issue(3, 1110, 1'b0);
        issue(4, 2497, 1'b0);
        issue(5, 666, 1'b0);
        bus.in_valid = 1'b0;
        drain();

        // Every invertible operand.
        for (int i = 1; i < 3329; i++) issue(i, inv_ref(i), 1'b0);
        bus.in_valid = 1'b0;
        drain();

        check("final_sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
